// File: rtl/tpu_pkg.sv
// Shared types for the systolic array output path:
// drain FSM states, the realigned row bundle and the default psum width.
package tpu_pkg;

  localparam int DRAIN_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH
  } drain_state_e;

  typedef struct packed {
    logic [DRAIN_DATA_WIDTH-1:0] lane2;
    logic [DRAIN_DATA_WIDTH-1:0] lane1;
  } row_t;

endpackage

// File: rtl/drain_row_fifo.sv
// Synchronous row FIFO with full/empty; read data is zero while empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module drain_row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/systolic_drain.sv
// Systolic array drain: deskews column psums into rows, buffers them, counts.
// Optional SYSTOLIC_DRAIN_RELU_EN clamps negative lanes to zero at push.
module systolic_drain
  import tpu_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int DATA_WIDTH           = DRAIN_DATA_WIDTH,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_start_in,
  input  logic [15:0]           drain_rows_in,
  input  logic [15:0]           ub_rd_col_size_in,
  input  logic                  ub_rd_col_size_valid_in,
  input  logic [DATA_WIDTH-1:0] sys_data_in_1,
  input  logic [DATA_WIDTH-1:0] sys_data_in_2,
  input  logic                  sys_valid_in_1,
  input  logic                  sys_valid_in_2,
  output logic [DATA_WIDTH-1:0] ub_wr_data_out_1,
  output logic [DATA_WIDTH-1:0] ub_wr_data_out_2,
  output logic                  ub_wr_valid_out,
  input  logic                  ub_wr_ready_in,
  output logic                  drain_busy_out,
  output logic                  drain_done_out,
  output logic                  err_overflow_out,
  output logic                  err_misalign_out
);

  localparam logic [1:0] CS_MAX = 2'(SYSTOLIC_ARRAY_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] lane2;
    logic [DATA_WIDTH-1:0] lane1;
  } lrow_t;

  drain_state_e          state_q;
  logic [15:0]           rows_left_q;
  logic [1:0]            col_size_q;
  logic                  sk_v_q;
  logic [DATA_WIDTH-1:0] sk_d_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  mis_q;

  logic  collect, two_col;
  logic  pair, frag, pop, drop;
  logic  fifo_full, fifo_empty;
  lrow_t wrow, rrow;

  always_comb begin
    collect    = (state_q == ST_COLLECT);
    two_col    = (col_size_q == 2'd2);
    pair       = collect && sk_v_q && (!two_col || sys_valid_in_2);
    frag       = collect && two_col && (sk_v_q ^ sys_valid_in_2);
    pop        = !fifo_empty && ub_wr_ready_in;
    drop       = pair && fifo_full && !pop;
    wrow.lane1 = sk_d_q;
    wrow.lane2 = two_col ? sys_data_in_2 : '0;
`ifdef SYSTOLIC_DRAIN_RELU_EN
    if (wrow.lane1[DATA_WIDTH-1]) wrow.lane1 = '0;
    if (wrow.lane2[DATA_WIDTH-1]) wrow.lane2 = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_size_q <= CS_MAX;
    end else if (ub_rd_col_size_valid_in) begin
      col_size_q <= (ub_rd_col_size_in == 16'd1) ? 2'd1 : CS_MAX;
    end
  end

  // Skew register only tracks column 1 while collecting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rows_left_q <= '0;
      sk_v_q      <= 1'b0;
      sk_d_q      <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      sk_v_q <= collect && sys_valid_in_1;
      sk_d_q <= collect ? sys_data_in_1 : '0;
      if (drop) ovf_q <= 1'b1;
      if (frag) mis_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (drain_start_in) begin
            rows_left_q <= drain_rows_in;
            ovf_q       <= 1'b0;
            mis_q       <= 1'b0;
            state_q     <= (drain_rows_in == 16'd0) ?
                           ST_FLUSH : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (pair) begin
            rows_left_q <= rows_left_q - 16'd1;
            if (rows_left_q == 16'd1) state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  drain_row_fifo #(
    .WIDTH(2 * DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (pair),
    .wdata_i(wrow),
    .pop_i  (pop),
    .rdata_o(rrow),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign ub_wr_data_out_1 = rrow.lane1;
  assign ub_wr_data_out_2 = rrow.lane2;
  assign ub_wr_valid_out  = !fifo_empty;
  assign drain_busy_out   = (state_q != ST_IDLE);
  assign drain_done_out   = done_q;
  assign err_overflow_out = ovf_q;
  assign err_misalign_out = mis_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: per-cycle vector table plus
// hand sequences for reset mid-drain, zero-row drain and the ReLU option.
module tb_systolic_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] rows;
  logic [15:0] cs;
  logic        csv;
  logic [15:0] d1, d2;
  logic        v1, v2;
  logic [15:0] o1, o2;
  logic        ov, rdy, busy, done, eovf, emis;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_drain #(
    .SYSTOLIC_ARRAY_WIDTH(2),
    .DATA_WIDTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .drain_start_in         (start),
    .drain_rows_in          (rows),
    .ub_rd_col_size_in      (cs),
    .ub_rd_col_size_valid_in(csv),
    .sys_data_in_1          (d1),
    .sys_data_in_2          (d2),
    .sys_valid_in_1         (v1),
    .sys_valid_in_2         (v2),
    .ub_wr_data_out_1       (o1),
    .ub_wr_data_out_2       (o2),
    .ub_wr_valid_out        (ov),
    .ub_wr_ready_in         (rdy),
    .drain_busy_out         (busy),
    .drain_done_out         (done),
    .err_overflow_out       (eovf),
    .err_misalign_out       (emis)
  );

  typedef struct {
    logic        st;
    logic [15:0] rows;
    logic        csv;
    logic [15:0] cs;
    logic        v1;
    logic [15:0] d1;
    logic        v2;
    logic [15:0] d2;
    logic        rdy;
    logic        ev;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eb;
    logic        ed;
    logic        eo;
    logic        em;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic st, input logic [15:0] rw,
    input logic sv, input logic [15:0] c,
    input logic a1, input logic [15:0] x1,
    input logic a2, input logic [15:0] x2,
    input logic r, input logic ev,
    input logic [15:0] e1, input logic [15:0] e2,
    input logic eb, input logic ed,
    input logic eo, input logic em);
    vec_t v;
    v.st = st; v.rows = rw; v.csv = sv; v.cs = c;
    v.v1 = a1; v.d1 = x1; v.v2 = a2; v.d2 = x2;
    v.rdy = r; v.ev = ev; v.e1 = e1; v.e2 = e2;
    v.eb = eb; v.ed = ed; v.eo = eo; v.em = em;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    start = 0; rows = 0; csv = 0; cs = 0;
    v1 = 0; d1 = 0; v2 = 0; d2 = 0;
  endtask

  task automatic drive(input vec_t v);
    start = v.st; rows = v.rows; csv = v.csv; cs = v.cs;
    v1 = v.v1; d1 = v.d1; v2 = v.v2; d2 = v.d2;
    rdy = v.rdy;
  endtask

  task automatic chk_status(input string tag, input logic eb,
                            input logic ed, input logic eo,
                            input logic em);
    chk({tag, " busy"}, busy, eb);
    chk({tag, " done"}, done, ed);
    chk({tag, " ovf"}, eovf, eo);
    chk({tag, " mis"}, emis, em);
  endtask

  initial begin
    logic [15:0] relu1;
    rst = 1'b0; rdy = 1'b1;
    idle_in();

    // two rows, ready high
    vq.push_back(mk(1,2,0,0, 0,0,0,0,1, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,5,0,0,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,7,1,6,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,1,8,1, 1,5,6,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,7,8,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,0,0,0,0));
    // one column, stray col2 valid ignored
    vq.push_back(mk(0,0,1,1, 0,0,0,0,1, 0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,0, 0,0,0,0,1, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,16'h42,1,16'h99,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,1,16'h77,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,16'h42,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,0,1,0,0));
    // col size 0 clamps to 2; five rows into depth 4 with ready low
    vq.push_back(mk(0,0,1,0, 0,0,0,0,0, 0,0,0,0,0,0,0));
    vq.push_back(mk(1,5,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,0,0,0, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,2,1,11,0, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,3,1,12,0, 1,1,11,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,4,1,13,0, 1,1,11,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,5,1,14,0, 1,1,11,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,1,15,0, 1,1,11,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,1,11,1,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,1,11,1,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,2,12,1,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,3,13,1,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,4,14,1,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,1,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,0,1,1,0));
    // col size 3 clamps to 2; lone col1 fragment then a good pair
    vq.push_back(mk(0,0,1,3, 0,0,0,0,1, 0,0,0,0,0,1,0));
    vq.push_back(mk(1,1,0,0, 0,0,0,0,1, 0,0,0,0,0,1,0));
    vq.push_back(mk(0,0,0,0, 1,9,0,0,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,16'h21,0,0,1, 0,0,0,1,0,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,1,16'h22,1, 0,0,0,1,0,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 1,16'h21,16'h22,1,0,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,1,0,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,1, 0,0,0,0,1,0,1));

    repeat (2) @(negedge clk);
    chk("reset valid", ov, 1'b0);
    chk_status("reset", 0, 0, 0, 0);
    rst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d valid", i), ov, vq[i].ev);
      if (vq[i].ev) begin
        chk($sformatf("v%0d lane1", i), o1, vq[i].e1);
        chk($sformatf("v%0d lane2", i), o2, vq[i].e2);
      end
      chk_status($sformatf("v%0d", i),
                 vq[i].eb, vq[i].ed, vq[i].eo, vq[i].em);
      drive(vq[i]);
    end

    // reset mid-drain with two rows buffered
    @(negedge clk);
    idle_in(); rdy = 0; start = 1; rows = 3;
    @(negedge clk);
    idle_in(); v1 = 1; d1 = 16'h1;
    @(negedge clk);
    v1 = 1; d1 = 16'h2; v2 = 1; d2 = 16'h31;
    @(negedge clk);
    v1 = 0; d1 = 0; v2 = 1; d2 = 16'h32;
    @(negedge clk);
    idle_in();
    chk("mid valid", ov, 1'b1);
    chk("mid lane1", o1, 16'h1);
    chk("mid busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst valid", ov, 1'b0);
    chk("arst lane1", o1, 16'h0);
    chk("arst lane2", o2, 16'h0);
    chk_status("arst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; rdy = 1;
    @(negedge clk);
    chk("post valid", ov, 1'b0);
    chk("post busy", busy, 1'b0);
    start = 1; rows = 1;
    @(negedge clk);
    idle_in(); v1 = 1; d1 = 16'h55;
    @(negedge clk);
    idle_in(); v2 = 1; d2 = 16'h66;
    @(negedge clk);
    idle_in();
    chk("post2 valid", ov, 1'b1);
    chk("post2 lane1", o1, 16'h55);
    chk("post2 lane2", o2, 16'h66);
    @(negedge clk);
    chk("post2 empty", ov, 1'b0);
    chk("post2 busy", busy, 1'b1);
    @(negedge clk);
    chk("post2 done", done, 1'b1);

    // zero-row drain completes through flush
    start = 1; rows = 0;
    @(negedge clk);
    idle_in();
    chk("zero busy", busy, 1'b1);
    chk("zero done0", done, 1'b0);
    @(negedge clk);
    chk("zero done", done, 1'b1);
    chk("zero idle", busy, 1'b0);

    // negative psum through the optional clamp
`ifdef SYSTOLIC_DRAIN_RELU_EN
    relu1 = 16'h0000;
`else
    relu1 = 16'hFFFD;
`endif
    start = 1; rows = 1;
    @(negedge clk);
    idle_in(); v1 = 1; d1 = 16'hFFFD;
    @(negedge clk);
    idle_in(); v2 = 1; d2 = 16'd9;
    @(negedge clk);
    idle_in();
    chk("relu valid", ov, 1'b1);
    chk("relu lane1", o1, relu1);
    chk("relu lane2", o2, 16'd9);
    repeat (3) @(negedge clk);
    chk("relu idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
